// File: rtl/full_subtractor.sv
// Single-bit full subtractor (x - y - z) with combinational outputs, a registered
// copy of both results and a saturating count of borrow cycles.
module full_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic       difference,
    output logic       borrow,
    output logic       difference_q,
    output logic       borrow_q,
    output logic [7:0] borrow_count
);

    localparam logic [7:0] COUNT_MAX = 8'd255;

    // Zero-delay path into the next stage of a ripple chain; never gated by clk or rst.
    assign difference = x ^ y ^ z;
    assign borrow     = (~x & y) | (~x & z) | (y & z);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            difference_q <= 1'b0;
            borrow_q     <= 1'b0;
            borrow_count <= 8'd0;
        end else begin
            difference_q <= difference;
            borrow_q     <= borrow;
            if (borrow && (borrow_count != COUNT_MAX))
                borrow_count <= borrow_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random self-checking bench for full_subtractor.
`timescale 1ns/1ps
module tb_full_subtractor;

    logic       clk;
    logic       rst;
    logic       x, y, z;
    logic       difference, borrow, difference_q, borrow_q;
    logic [7:0] borrow_count;

    int passed = 0;
    int total  = 0;

    // Hand-computed truth table, bit index = {x,y,z}.
    logic [7:0] diff_table   = 8'b1001_0110;
    logic [7:0] borrow_table = 8'b1000_1110;

    full_subtractor dut (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .y            (y),
        .z            (z),
        .difference   (difference),
        .borrow       (borrow),
        .difference_q (difference_q),
        .borrow_q     (borrow_q),
        .borrow_count (borrow_count)
    );

    // One full clock period: rising edge after 5, falling edge after 10; returns in low phase.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic set_in(input logic [2:0] v);
        {x, y, z} = v;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({difference_q, borrow_q, borrow_count} !== 10'd0)
            $display("FAIL reset_state: dq=%b bq=%b cnt=%0d, required 0/0/0",
                     difference_q, borrow_q, borrow_count);
        else passed++;
        rst = 1'b0;
        #4;
    endtask

    task automatic test_comb_sweep();
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i));
            #5;
            total++;
            if ({difference, borrow} !== {diff_table[i], borrow_table[i]})
                $display("FAIL comb_sweep xyz=%03b: d/b=%b/%b, required %b/%b",
                         3'(i), difference, borrow, diff_table[i], borrow_table[i]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        set_in(3'b111);
        tick();
        total++;
        if ({difference_q, borrow_q} !== 2'b11 || borrow_count === 8'd0)
            $display("FAIL pre_reset_state: dq=%b bq=%b cnt=%0d, required 1/1/nonzero",
                     difference_q, borrow_q, borrow_count);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({difference_q, borrow_q, borrow_count} !== 10'd0)
            $display("FAIL async_reset: dq=%b bq=%b cnt=%0d, required 0/0/0",
                     difference_q, borrow_q, borrow_count);
        else passed++;
        total++;
        if ({difference, borrow} !== 2'b11)
            $display("FAIL comb_during_reset: d/b=%b/%b, required 1/1", difference, borrow);
        else passed++;
        // Clock edge while reset is held: registers must stay cleared.
        #2 clk = 1'b1;
        #1;
        total++;
        if ({difference_q, borrow_q, borrow_count} !== 10'd0)
            $display("FAIL reset_wins_edge: dq=%b bq=%b cnt=%0d, required 0/0/0",
                     difference_q, borrow_q, borrow_count);
        else passed++;
        #4 clk = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        set_in(3'b011);
        #5 clk = 1'b1;
        #1 set_in(3'b100);
        #1;
        total++;
        if ({difference_q, borrow_q} !== 2'b01)
            $display("FAIL latency_edge1: dq/bq=%b/%b, required 0/1", difference_q, borrow_q);
        else passed++;
        total++;
        if ({difference, borrow} !== 2'b10)
            $display("FAIL latency_comb: d/b=%b/%b, required 1/0", difference, borrow);
        else passed++;
        #3 clk = 1'b0;
        tick();
        total++;
        if ({difference_q, borrow_q} !== 2'b10)
            $display("FAIL latency_edge2: dq/bq=%b/%b, required 1/0", difference_q, borrow_q);
        else passed++;
    endtask

    task automatic test_counter_saturation();
        int exp_count;
        rst = 1'b1;
        #1 rst = 1'b0;
        set_in(3'b001);
        for (int i = 1; i <= 300; i++) begin
            tick();
            exp_count = (i > 255) ? 255 : i;
            total++;
            if (borrow_count !== 8'(exp_count))
                $display("FAIL count_step edge=%0d: cnt=%0d, required %0d", i, borrow_count, exp_count);
            else passed++;
        end
        set_in(3'b100);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (borrow_count !== 8'd255)
                $display("FAIL count_hold edge=%0d: cnt=%0d, required 255", i, borrow_count);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_count();
        rst = 1'b1;
        #1 rst = 1'b0;
        set_in(3'b001);
        repeat (17) tick();
        total++;
        if (borrow_count !== 8'd17)
            $display("FAIL mid_count_pre: cnt=%0d, required 17", borrow_count);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (borrow_count !== 8'd0)
            $display("FAIL mid_count_reset: cnt=%0d, required 0", borrow_count);
        else passed++;
        #4 rst = 1'b0;
        tick();
        total++;
        if (borrow_count !== 8'd1)
            $display("FAIL mid_count_after_release: cnt=%0d, required 1", borrow_count);
        else passed++;
    endtask

    task automatic test_random();
        int r, exp_d, exp_b;
        for (int i = 0; i < 1000; i++) begin
            set_in(3'($urandom_range(0, 7)));
            #1;
            r = int'(x) - int'(y) - int'(z);
            total++;
            if (int'(difference) - 2 * int'(borrow) !== r)
                $display("FAIL random_identity cyc=%0d xyz=%b%b%b: d-2b=%0d, required %0d",
                         i, x, y, z, int'(difference) - 2 * int'(borrow), r);
            else passed++;
            exp_b = (r < 0) ? 1 : 0;
            exp_d = r + 2 * exp_b;
            #4 clk = 1'b1;
            #1 set_in(3'($urandom_range(0, 7)));
            total++;
            if ({difference_q, borrow_q} !== {1'(exp_d), 1'(exp_b)})
                $display("FAIL random_registered cyc=%0d: dq/bq=%b/%b, required %0d/%0d",
                         i, difference_q, borrow_q, exp_d, exp_b);
            else passed++;
            #4 clk = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        set_in(3'b000);
        test_reset();
        test_comb_sweep();
        test_async_reset();
        test_latency();
        test_counter_saturation();
        test_reset_mid_count();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
